// File: rtl/rgb_to_axis_if.sv
// rgb_to_axis_if: AXI4-Stream video beat bus
interface rgb_to_axis_if;
  logic [23:0] tdata;
  logic tvalid, tready, tuser, tlast;
  modport master(output tdata, tvalid, tuser, tlast, input tready);
  modport slave(input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/rgb_to_axis.sv
// rgb_to_axis: decoded HDMI pixels to AXI4-Stream video with timing lock and pixel FIFO
module rgb_to_axis #(
  parameter int FIFO_DEPTH = 32,
  parameter int LOCK_FRAMES = 2,
  parameter int CNT_W = 12
) (
  input  logic rxclk,
  input  logic exrst_n,
  input  logic hsync,
  input  logic vsync,
  input  logic de,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  rgb_to_axis_if.master m_axis,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active,
  output logic locked,
  output logic overflow,
  input  logic ovf_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic s1_hs, s1_vs, s1_de, vs_d, s2_v;
  logic [23:0] s1_px, s2_px;
  logic [CNT_W-1:0] hcnt, vcnt, first_len;
  logic bad, armed, sof;
  logic [LW-1:0] lock_cnt, lock_nx;
  logic [25:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic frame_end, line_end, good, lock_new, empty, full, wr_req, wr_en, rd_en;
  always_comb begin
    frame_end = s1_vs & ~vs_d;
    line_end = s2_v & ~s1_de;
    good = ~bad & (first_len != '0) & (vcnt != '0) & (first_len == h_active) & (vcnt == v_active);
    lock_nx = !good ? '0 : (lock_cnt == LW'(LOCK_FRAMES)) ? lock_cnt : lock_cnt + LW'(1);
    lock_new = lock_nx == LW'(LOCK_FRAMES);
    empty = wp == rp;
    full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    wr_req = armed & s2_v;
    wr_en = wr_req & ~full;
    rd_en = m_axis.tvalid & m_axis.tready;
  end
  assign m_axis.tvalid = ~empty;
  assign {m_axis.tuser, m_axis.tlast, m_axis.tdata} = empty ? '0 : mem[rp[AW-1:0]];
  // tlast is decided when the pixel behind this one turns out to be blanking
  always_ff @(posedge rxclk)
    if (wr_en) mem[wp[AW-1:0]] <= {sof, ~s1_de, s2_px};
  always_ff @(posedge rxclk) begin
    if (!exrst_n) begin
      {s1_hs, s1_vs, s1_de, vs_d, s2_v} <= '0;
      s1_px <= '0;
      s2_px <= '0;
      hcnt <= '0;
      vcnt <= '0;
      first_len <= '0;
      bad <= 1'b0;
      armed <= 1'b0;
      sof <= 1'b0;
      lock_cnt <= '0;
      locked <= 1'b0;
      h_active <= '0;
      v_active <= '0;
      overflow <= 1'b0;
      wp <= '0;
      rp <= '0;
    end else begin
      s1_hs <= hsync;
      s1_vs <= vsync;
      s1_de <= de;
      s1_px <= {red, blue, green};
      vs_d <= s1_vs;
      s2_v <= s1_de;
      s2_px <= s1_px;
      hcnt <= s1_de ? ((hcnt == CMAX) ? hcnt : hcnt + CNT_W'(1)) : (line_end | s1_hs) ? '0 : hcnt;
      if (frame_end) begin
        vcnt <= '0;
        first_len <= '0;
        bad <= 1'b0;
        h_active <= first_len;
        v_active <= vcnt;
        lock_cnt <= lock_nx;
        locked <= lock_new;
        armed <= lock_new;
        sof <= lock_new;
      end else begin
        if (line_end) begin
          vcnt <= (vcnt == CMAX) ? vcnt : vcnt + CNT_W'(1);
          if (vcnt == '0) first_len <= hcnt;
          else if (hcnt != first_len) bad <= 1'b1;
        end
        if (wr_req & full) armed <= 1'b0;
        if (wr_en) sof <= 1'b0;
      end
      if (wr_en) wp <= wp + (AW+1)'(1);
      if (rd_en) rp <= rp + (AW+1)'(1);
      overflow <= (wr_req & full) | (overflow & ~ovf_clr);
    end
  end
endmodule

// File: tb/tb_rgb_to_axis.sv
// tb_rgb_to_axis: random-data frame stimulus against a frame-level lock/stream model
module tb_rgb_to_axis;
  localparam int LOCK = 2;
  logic clk = 0, exrst_n, hsync, vsync, de, ovf_clr, locked, overflow;
  logic [7:0] red, green, blue;
  logic [11:0] h_active, v_active;
  rgb_to_axis_if ax();
  rgb_to_axis dut(.rxclk(clk), .exrst_n(exrst_n), .hsync(hsync), .vsync(vsync), .de(de),
    .red(red), .green(green), .blue(blue), .m_axis(ax), .h_active(h_active),
    .v_active(v_active), .locked(locked), .overflow(overflow), .ovf_clr(ovf_clr));
  always #5 clk = ~clk;
  int errors = 0, checks = 0, rmode = 1, hb = 8;
  int m_h = 0, m_v = 0, lc = 0;
  bit m_lock = 0, m_armed = 0;
  logic [25:0] q[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    ax.tready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
  endtask
  task automatic set_mode(input int m);
    rmode = m;
    ax.tready = (m == 1);
  endtask
  always @(negedge clk)
    if (ax.tvalid && ax.tready)
      check("beat", {6'd0, ax.tuser, ax.tlast, ax.tdata}, (q.size() != 0) ? {6'd0, q.pop_front()} : 32'hffff_ffff);
  // wl: width of the last line; cap: pixels expected before the FIFO overflows; rst_at: pixel index of a reset pulse
  task automatic frame(input int w, input int h, input int wl, input int cap, input bit idx, input int rst_at);
    int n, lw;
    bit arm, did_rst, ok;
    logic [23:0] d;
    n = 0;
    arm = m_armed;
    did_rst = 0;
    for (int l = 0; l < h; l++) begin
      lw = (l == h - 1) ? wl : w;
      for (int p = 0; p < lw; p++) begin
        d = idx ? 24'(n) : 24'($urandom);
        de = 1;
        red = d[23:16];
        blue = d[15:8];
        green = d[7:0];
        if (n == rst_at) begin
          exrst_n = 0;
          did_rst = 1;
          arm = 0;
          q.delete();
        end else if (arm && n < cap) q.push_back({n == 0, p == lw - 1, d});
        n++;
        tick();
        if (!exrst_n) begin
          exrst_n = 1;
          check("rst_tvalid", ax.tvalid, 0);
          check("rst_locked", locked, 0);
          check("rst_h_active", h_active, 0);
        end
      end
      de = 0;
      for (int i = 0; i < hb; i++) begin
        hsync = (i >= 2 && i < 4);
        tick();
      end
      hsync = 0;
    end
    repeat (4) tick();
    vsync = 1;
    repeat (3) tick();
    vsync = 0;
    repeat (4) tick();
    if (did_rst) begin
      lc = 0;
      m_lock = 0;
      m_h = -1;
      m_v = -1;
    end else begin
      ok = (wl == w) && w != 0 && h != 0 && w == m_h && h == m_v;
      lc = !ok ? 0 : (lc < LOCK) ? lc + 1 : lc;
      m_lock = (lc == LOCK);
      m_h = w;
      m_v = h;
      check("h_active", h_active, w);
      check("v_active", v_active, h);
    end
    check("locked", locked, m_lock);
    m_armed = m_lock;
  endtask
  task automatic drain();
    for (int i = 0; i < 3000 && q.size() != 0; i++) tick();
    check("drain_left", q.size(), 0);
  endtask
  initial begin
    exrst_n = 0;
    {hsync, vsync, de, ovf_clr} = '0;
    {red, green, blue} = '0;
    set_mode(1);
    repeat (3) tick();
    exrst_n = 1;
    tick();
    check("rst_tvalid0", ax.tvalid, 0);
    check("rst_tdata0", ax.tdata, 0);
    check("rst_locked0", locked, 0);
    check("rst_overflow0", overflow, 0);
    check("rst_h0", h_active, 0);
    check("rst_v0", v_active, 0);
    repeat (4) frame(8, 4, 8, 9999, 0, -1);
    frame(8, 4, 8, 9999, 1, -1);
    drain();
    frame(8, 4, 6, 9999, 0, -1);
    repeat (2) frame(8, 4, 8, 9999, 0, -1);
    repeat (3) frame(10, 4, 10, 9999, 0, -1);
    drain();
    repeat (3) frame(8, 8, 8, 9999, 0, -1);
    drain();
    set_mode(0);
    frame(8, 8, 8, 32, 0, -1);
    check("overflow_set", overflow, 1);
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    check("overflow_clr", overflow, 0);
    set_mode(1);
    drain();
    frame(8, 8, 8, 9999, 1, -1);
    drain();
    set_mode(0);
    frame(8, 4, 8, 9999, 0, 13);
    set_mode(2);
    hb = 40;
    repeat (6) frame(16, 8, 16, 9999, 0, -1);
    drain();
    check("overflow_end", overflow, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
